// File: rtl/fibonacci_seq_if.sv
// Output stream bundle for the Fibonacci sequence engine.
// Producer drives data/valid/last, consumer drives ready.
interface fibonacci_seq_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/fibonacci_seq.sv
// Generalised Fibonacci engine with programmable seeds.
// Single-result or stream mode, valid/ready output, overflow flag.
module fibonacci_seq #(
  parameter int WIDTH    = 16,
  parameter int IDX_W    = 5,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [IDX_W-1:0] n,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic             mode_stream,
  input  logic             abort,
  output logic             busy,
  output logic             overflow,
  output logic             done,
  fibonacci_seq_if.master  o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_OUT,
    S_STREAM,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   sum_full;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             fire;
  logic             valid;

  // Next term, wrapped or clamped on carry-out
  always_comb begin
    sum_full = {1'b0, a_q} + {1'b0, b_q};
    carry    = sum_full[WIDTH];
    if (SATURATE != 0 && carry) sum = '1;
    else                        sum = sum_full[WIDTH-1:0];
  end

  // Outputs decoded from state; abort suppresses a pending beat
  always_comb begin
    valid      = (state_q == S_OUT || state_q == S_STREAM) && !abort;
    fire       = valid && o.out_ready;
    busy       = state_q != S_IDLE;
    done       = state_q == S_DONE;
    overflow   = ovf_q;
    o.out_valid = valid;
    o.out_last = (state_q == S_OUT) ||
                 (state_q == S_STREAM && cnt_q == '0);
    o.out_data = (state_q == S_STREAM) ? a_q : res_q;
  end

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            a_d     = seed0;
            b_d     = seed1;
            cnt_d   = n;
            ovf_d   = 1'b0;
            state_d = mode_stream ? S_STREAM : S_CALC;
          end
        end
        S_CALC: begin
          if (cnt_q < IDX_W'(2)) begin
            res_d   = (cnt_q == '0) ? a_q : b_q;
            state_d = S_OUT;
          end else begin
            a_d   = b_q;
            b_d   = sum;
            cnt_d = cnt_q - IDX_W'(1);
            if (carry) ovf_d = 1'b1;
          end
        end
        S_OUT: begin
          if (fire) state_d = S_DONE;
        end
        S_STREAM: begin
          if (fire) begin
            if (cnt_q == '0) begin
              state_d = S_DONE;
            end else begin
              a_d   = b_q;
              b_d   = sum;
              cnt_d = cnt_q - IDX_W'(1);
              // b_q+a_q is term k+2; only count it when k+2 <= n
              if (carry && cnt_q >= IDX_W'(2)) ovf_d = 1'b1;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: doc/fibonacci_seq.md
Name: fibonacci_seq

Overview:
- Parametrised second-generation Fibonacci-type sequence engine for the datapath.
- Computes a generalised recurrence with programmable seeds: F(0)=seed0, F(1)=seed1, F(k)=F(k-1)+F(k-2).
- Two modes: single-result mode returns F(n) only; stream mode emits F(0)..F(n) in order.
- Output uses a valid/ready handshake with backpressure. The block also provides overflow detection with a wrap or saturate policy, and an abort input.

Parameters:
- WIDTH, 16: data width of seeds, terms and out_data.
- IDX_W, 5: width of the index n.
- SATURATE, 0: 0 = sums wrap modulo 2^WIDTH; 1 = sums clamp to all-ones on carry-out.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- n  in  IDX_W  target index; captured on accepted start.
- seed0  in  WIDTH  F(0); captured on accepted start.
- seed1  in  WIDTH  F(1); captured on accepted start.
- mode_stream  in  1  0 = single result, 1 = stream all terms; captured on accepted start.
- abort  in  1  cancels the current job.
- busy  out  1  high in every state except IDLE.
- out_data  out  WIDTH  result or stream term.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the beat.
- out_last  out  1  marks the final beat; qualified by out_valid.
- overflow  out  1  sticky per job; cleared on accepted start.
- done  out  1  one-cycle pulse after the final handshake.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy, out_valid, out_last, done and overflow = 0; out_data = 0; internal a, b and cnt = 0.
- States: IDLE, CALC, OUT, STREAM, DONE.
- Handshake: a beat transfers on a rising edge with out_valid && out_ready.
  - Once out_valid is asserted, out_data and out_last stay stable until the transfer.
  - out_valid never depends combinationally on out_ready.
- IDLE:
  - On start=1: a<=seed0, b<=seed1, cnt<=n, overflow<=0, mode latched.
  - Next state is CALC when mode_stream=0, STREAM when mode_stream=1.
  - start while busy is ignored; no queuing.
- CALC (single-result mode):
  - If cnt<=1: out_data <= (cnt==0 ? a : b); go to OUT.
  - Otherwise: a<=b, b<=sum(a,b), cnt<=cnt-1.
  - CALC occupies max(n,1) cycles. out_valid first rises at edge T0+max(n,1)+1, where T0 is the edge that sampled start.
- OUT: out_valid=1, out_last=1. Hold until the handshake, then go to DONE.
- STREAM:
  - out_valid=1, out_data=a, out_last=(cnt==0).
  - On handshake with cnt!=0: a<=b, b<=sum(a,b), cnt<=cnt-1.
  - On handshake with cnt==0: go to DONE.
  - First beat is valid at edge T0+1. Exactly n+1 beats are emitted; with out_ready held high, one beat per cycle.
- DONE: done=1 for exactly one cycle, busy still 1; then IDLE. A start can be accepted in the IDLE cycle immediately after DONE.
- Arithmetic:
  - sum is computed WIDTH+1 bits wide.
  - carry=1 with SATURATE=0: the low WIDTH bits are kept.
  - carry=1 with SATURATE=1: the result is 2^WIDTH-1.
- Overflow flag:
  - Set only when a carry occurs while producing a term with index <= n.
  - Carries on look-ahead terms beyond n (stream mode computes F(k+1), F(k+2) ahead) must not set it.
  - The flag is held until the next accepted start.
- Abort:
  - abort=1 in any non-IDLE state: next state IDLE, out_valid=0, no done pulse.
  - overflow keeps its value. A pending beat is dropped even if out_ready is high in the same cycle; abort wins.
- Boundaries:
  - n=0 returns/emits seed0 only (stream: single beat, out_last=1).
  - n=1 returns seed1.
  - n=2^IDX_W-1 is legal; cnt never wraps.
- Reset mid-operation: asynchronous return to reset values; any in-flight job is lost.

Test Plan:
- WIDTH=16, seeds 0/1, single mode, n=10, out_ready=1 -> out_data=55 with out_valid at T0+11, out_last=1, done one cycle later, overflow=0. Also n=0 -> 0 at T0+2; n=1 -> 1 at T0+2.
- Stream mode, seeds 0/1, n=5, out_ready toggled 1,0,0,1,... -> beats 0,1,1,2,3,5 in order. Data is held stable during stalls, out_last only on 5, done after the final handshake.
- Lucas seeds 2/1, n=4, single mode -> 7. The same job in stream mode -> 2,1,3,4,7.
- Overflow, WIDTH=16, seeds 0/1:
  - n=24 -> 46368 with overflow=0.
  - n=25, SATURATE=0 -> 9489 with overflow=1.
  - n=25, SATURATE=1 -> 65535 with overflow=1.
  - Stream n=24 -> overflow stays 0 despite look-ahead carries.
- Abort and start rules:
  - Abort during CALC at cycle T0+3 of an n=20 job -> IDLE next cycle, no out_valid, no done.
  - start during busy -> ignored.
  - A new start right after abort -> correct result.
- Reset asserted mid-stream with out_valid high -> all outputs 0 immediately (asynchronous). After deassertion the block stays in IDLE until start.
